// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Multi-cycle control sequencer for a combinational ALU. It accepts 16-bit
//   instruction words over a valid/ready handshake and decodes them into ALU
//   group enables and an op code. Operands come from an internal 8 x N
//   register file. The ALU result and carry are captured and written back.
//
//   Instruction word: [15:13] class (000 arith, 001 shift, 010 load),
//   [12:10] op, [9:7] rd, [6:4] rs1, [3:1] rs2, [0] imm flag.
//   When the imm flag is set, the next word is the immediate and replaces rs2.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   instr_valid/ready   handshake for instruction and immediate words
//   instr_data          instruction or immediate word
//   done                one-cycle pulse during writeback
//   error               one-cycle pulse after an illegal instruction is accepted
//   dbg_addr/dbg_data   combinational debug read of the register file
//   carry_flag          current carry flag
//   alu_*               registered ALU controls, nonzero only in EXEC
//   alu_result/alu_carry_out  ALU outputs, captured at the end of EXEC
//
// Configuration
//   ALU_SEQ_R0_ZERO_EN  when defined, R0 reads as zero and writes to it are
//                       dropped. Carry and done behave as usual.
//
// State | Meaning
// IDLE  | waiting for an instruction word
// IMM   | imm instruction latched, waiting for the immediate word
// EXEC  | alu_* driven; ALU result and carry captured at the end of the cycle
// WB    | done high; R[rd] and carry_flag written at the end of the cycle
module alu_sequencer #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         instr_valid,
  output logic         instr_ready,
  input  logic [15:0]  instr_data,
  output logic         done,
  output logic         error,
  input  logic [2:0]   dbg_addr,
  output logic [N-1:0] dbg_data,
  output logic         carry_flag,
  output logic [N-1:0] alu_operand1,
  output logic [N-1:0] alu_operand2,
  output logic         alu_carry_in,
  output logic         alu_enable_alu,
  output logic         alu_enable_shift,
  output logic         alu_enable_load,
  output logic [2:0]   alu_operation,
  input  logic [N-1:0] alu_result,
  input  logic         alu_carry_out
);

  typedef enum logic [1:0] {IDLE, IMM, EXEC, WB} stateT;

  localparam logic [2:0] CLS_ARITH = 3'd0;
  localparam logic [2:0] CLS_SHIFT = 3'd1;
  localparam logic [2:0] CLS_LOAD  = 3'd2;

  stateT        state;
  logic [15:4]  instrReg;   // class, op, rd, rs1 of the instruction in flight
  logic [N-1:0] resultReg;
  logic         carryReg;
  logic [N-1:0] regFile [8];

  logic         accept;
  logic         launchNow;
  logic [15:4]  launchHi;
  logic [N-1:0] launchOp2;

  function automatic logic [N-1:0] readReg(input logic [2:0] addr);
`ifdef ALU_SEQ_R0_ZERO_EN
    return (addr == 3'd0) ? '0 : regFile[addr];
`else
    return regFile[addr];
`endif
  endfunction

  function automatic logic isIllegal(input logic [2:0] cls, input logic [2:0] op);
    return (cls > CLS_LOAD) || ((cls == CLS_SHIFT) && (op > 3'd4));
  endfunction

  assign instr_ready = !reset && ((state == IDLE) || (state == IMM));
  assign accept      = instr_valid && instr_ready;
  assign dbg_data    = readReg(dbg_addr);

  // From IDLE the ALU is launched straight from the offered word. From IMM it
  // is launched from the latched instruction, and the offered word is operand2.
  always_comb begin
    launchHi  = instr_data[15:4];
    launchOp2 = readReg(instr_data[3:1]);
    launchNow = 1'b0;
    if (state == IMM) begin
      launchHi  = instrReg;
      launchOp2 = instr_data[N-1:0];
      launchNow = accept;
    end else if (state == IDLE) begin
      launchNow = accept && !instr_data[0] && !isIllegal(instr_data[15:13], instr_data[12:10]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      instrReg         <= '0;
      resultReg        <= '0;
      carryReg         <= 1'b0;
      carry_flag       <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
      alu_operand1     <= '0;
      alu_operand2     <= '0;
      alu_carry_in     <= 1'b0;
      alu_enable_alu   <= 1'b0;
      alu_enable_shift <= 1'b0;
      alu_enable_load  <= 1'b0;
      alu_operation    <= 3'd0;
      regFile          <= '{default: '0};
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (isIllegal(instr_data[15:13], instr_data[12:10])) begin
              error <= 1'b1;
            end else begin
              instrReg <= instr_data[15:4];
              state    <= instr_data[0] ? IMM : EXEC;
            end
          end
        end
        IMM: begin
          if (accept) state <= EXEC;
        end
        EXEC: begin
          resultReg        <= alu_result;
          carryReg         <= alu_carry_out;
          alu_operand1     <= '0;
          alu_operand2     <= '0;
          alu_carry_in     <= 1'b0;
          alu_enable_alu   <= 1'b0;
          alu_enable_shift <= 1'b0;
          alu_enable_load  <= 1'b0;
          alu_operation    <= 3'd0;
          done             <= 1'b1;
          state            <= WB;
        end
        WB: begin
`ifdef ALU_SEQ_R0_ZERO_EN
          if (instrReg[9:7] != 3'd0) regFile[instrReg[9:7]] <= resultReg;
`else
          regFile[instrReg[9:7]] <= resultReg;
`endif
          carry_flag <= carryReg;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Operands are latched here, so rd == rs1/rs2 is safe.
      if (launchNow) begin
        alu_operand1     <= readReg(launchHi[6:4]);
        alu_operand2     <= launchOp2;
        alu_carry_in     <= carry_flag;
        alu_enable_alu   <= (launchHi[15:13] == CLS_ARITH);
        alu_enable_shift <= (launchHi[15:13] == CLS_SHIFT);
        alu_enable_load  <= (launchHi[15:13] == CLS_LOAD);
        alu_operation    <= launchHi[12:10];
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer
//   Self-checking bench for alu_sequencer. The bench plays the ALU with a
//   small reference function and keeps its own register/carry model; expected
//   writebacks go into a queue when an instruction is issued and are popped
//   when the sequencer pulses done.
//   Bench ALU ops: arith 0 ADD, 1 ADC, 2 SUB (carry = borrow), 3 AND, 4 OR,
//   5 XOR; shift 0 SHR, 1 SHL, 2 ROR, 3 ROL, 4 ASR; load 4 LDLI
//   {op2[15:8], op1[7:0]}, other load ops pass operand2.
module tb_alu_sequencer;
  localparam int N = 16;
`ifdef ALU_SEQ_R0_ZERO_EN
  localparam bit r0Zero = 1'b1;
`else
  localparam bit r0Zero = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         instr_valid = 1'b0;
  logic         instr_ready;
  logic [15:0]  instr_data = '0;
  logic         done;
  logic         error;
  logic [2:0]   dbg_addr = '0;
  logic [N-1:0] dbg_data;
  logic         carry_flag;
  logic [N-1:0] alu_operand1;
  logic [N-1:0] alu_operand2;
  logic         alu_carry_in;
  logic         alu_enable_alu;
  logic         alu_enable_shift;
  logic         alu_enable_load;
  logic [2:0]   alu_operation;
  logic [N-1:0] alu_result;
  logic         alu_carry_out;

  alu_sequencer #(.N(N)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
    .done(done), .error(error),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .carry_flag(carry_flag),
    .alu_operand1(alu_operand1), .alu_operand2(alu_operand2), .alu_carry_in(alu_carry_in),
    .alu_enable_alu(alu_enable_alu), .alu_enable_shift(alu_enable_shift),
    .alu_enable_load(alu_enable_load), .alu_operation(alu_operation),
    .alu_result(alu_result), .alu_carry_out(alu_carry_out)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int total = 0;
  int passed = 0;

  typedef struct {
    logic [2:0]  rd;
    logic [15:0] val;
    logic        c;
    int          lat;
  } expT;
  expT         sb[$];
  logic [15:0] mdlReg [8];
  logic        mdlCarry;

  function automatic logic [16:0] refAlu(input logic [2:0] cls, input logic [2:0] op,
                                         input logic [15:0] a, input logic [15:0] b,
                                         input logic cin);
    logic [16:0] r;
    r = '0;
    case (cls)
      3'd0: case (op)
        3'd0: r = {1'b0, a} + {1'b0, b};
        3'd1: r = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        3'd2: r = {1'b0, a} - {1'b0, b};
        3'd3: r = {1'b0, a & b};
        3'd4: r = {1'b0, a | b};
        3'd5: r = {1'b0, a ^ b};
        default: r = {1'b0, a};
      endcase
      3'd1: case (op)
        3'd0: r = {a[0], 1'b0, a[15:1]};
        3'd1: r = {a, 1'b0};
        3'd2: r = {a[0], a[0], a[15:1]};
        3'd3: r = {a[15], a[14:0], a[15]};
        3'd4: r = {a[0], a[15], a[15:1]};
        default: r = '0;
      endcase
      3'd2: r = (op == 3'd4) ? {1'b0, b[15:8], a[7:0]} : {1'b0, b};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Stand-in ALU driven by the sequencer's control outputs.
  logic [16:0] aluOut;
  always_comb begin
    aluOut = '0;
    if (alu_enable_alu)
      aluOut = refAlu(3'd0, alu_operation, alu_operand1, alu_operand2, alu_carry_in);
    else if (alu_enable_shift)
      aluOut = refAlu(3'd1, alu_operation, alu_operand1, alu_operand2, alu_carry_in);
    else if (alu_enable_load)
      aluOut = refAlu(3'd2, alu_operation, alu_operand1, alu_operand2, alu_carry_in);
  end
  assign alu_result    = aluOut[15:0];
  assign alu_carry_out = aluOut[16];

  function automatic logic [15:0] enc(input logic [2:0] cls, input logic [2:0] op,
                                      input logic [2:0] rd, input logic [2:0] rs1,
                                      input logic [2:0] rs2, input logic imm);
    return {cls, op, rd, rs1, rs2, imm};
  endfunction

  function automatic logic [15:0] mdlRead(input logic [2:0] a);
    return (r0Zero && a == 3'd0) ? 16'h0000 : mdlReg[a];
  endfunction

  task automatic push(input logic [2:0] rd, input logic [15:0] val, input logic c, input int lat);
    expT e;
    e.rd  = rd;
    e.val = (r0Zero && rd == 3'd0) ? 16'h0000 : val;
    e.c   = c;
    e.lat = lat;
    sb.push_back(e);
    if (!(r0Zero && rd == 3'd0)) mdlReg[rd] = val;
    mdlCarry = c;
  endtask

  task automatic predict(input logic [15:0] w, input logic [15:0] immW, input int lat);
    logic [15:0] a;
    logic [15:0] b;
    logic [16:0] r;
    a = mdlRead(w[6:4]);
    b = w[0] ? immW : mdlRead(w[3:1]);
    r = refAlu(w[15:13], w[12:10], a, b, mdlCarry);
    push(w[9:7], r[15:0], r[16], lat);
  endtask

  // Issues one instruction (plus immediate) and waits for done. Latency is
  // counted from the cycle the instruction word is accepted. Returns on the
  // cycle after writeback.
  task automatic runInstr(input logic [15:0] w, input bit hasImm, input logic [15:0] immW,
                          input int immDelay, output bit gotDone, output int lat);
    int acc;
    int n;
    gotDone = 1'b0;
    lat = -1;
    instr_valid = 1'b1;
    instr_data = w;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    acc = cycle;
    @(negedge clk);
    if (hasImm) begin
      instr_valid = 1'b0;
      repeat (immDelay) @(negedge clk);
      instr_valid = 1'b1;
      instr_data = immW;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    for (n = 0; n < 12; n++) begin
      if (done) begin
        gotDone = 1'b1;
        lat = cycle - acc;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (instr_ready !== 1'b0) $display("FAIL reset_ready: got %0b, expected 0", instr_ready);
    else passed++;
    total++;
    if ({done, error, carry_flag} !== 3'b000)
      $display("FAIL reset_flags: got done/error/carry=%b, expected 000", {done, error, carry_flag});
    else passed++;
    total++;
    if ({alu_operand1, alu_operand2, alu_carry_in, alu_enable_alu, alu_enable_shift,
         alu_enable_load, alu_operation} !== '0)
      $display("FAIL reset_alu_outputs: got nonzero alu_* (op1=%h op2=%h), expected 0", alu_operand1, alu_operand2);
    else passed++;
    reset = 1'b0;
    #1;
    total++;
    if (instr_ready !== 1'b1) $display("FAIL reset_ready_after: got %0b, expected 1", instr_ready);
    else passed++;
    @(negedge clk);
    for (int j = 0; j < 8; j++) begin
      dbg_addr = 3'(j);
      #1;
      total++;
      if (dbg_data !== 16'h0000) $display("FAIL reset_reg%0d: got %h, expected 0000", j, dbg_data);
      else passed++;
      @(negedge clk);
    end
    for (int j = 0; j < 8; j++) mdlReg[j] = 16'h0000;
    mdlCarry = 1'b0;
  endtask

  task automatic test_ldli();
    bit  g;
    int  l;
    expT e;
    push(3'd1, 16'h1200, 1'b0, 3);
    runInstr(enc(3'd2, 3'd4, 3'd1, 3'd0, 3'd0, 1'b1), 1'b1, 16'h1234, 0, g, l);
    e = sb.pop_front();
    dbg_addr = e.rd;
    #1;
    total++;
    if (g !== 1'b1 || l != e.lat) $display("FAIL ldli_latency: got done=%0b lat=%0d, expected lat %0d", g, l, e.lat);
    else passed++;
    total++;
    if (dbg_data !== e.val) $display("FAIL ldli_r1: got %h, expected %h", dbg_data, e.val);
    else passed++;
    // Immediate word offered two cycles late: two extra cycles in IMM.
    push(3'd2, 16'hABCD, 1'b0, 5);
    runInstr(enc(3'd2, 3'd0, 3'd2, 3'd0, 3'd0, 1'b1), 1'b1, 16'hABCD, 2, g, l);
    e = sb.pop_front();
    dbg_addr = e.rd;
    #1;
    total++;
    if (g !== 1'b1 || l != e.lat) $display("FAIL ld_imm_wait_latency: got done=%0b lat=%0d, expected lat %0d", g, l, e.lat);
    else passed++;
    total++;
    if (dbg_data !== e.val) $display("FAIL ld_imm_wait_r2: got %h, expected %h", dbg_data, e.val);
    else passed++;
  endtask

  task automatic test_arith();
    logic [15:0] w [4];
    logic [15:0] immw [4];
    logic [15:0] ev [4];
    logic        ec [4];
    w    = '{enc(3'd2, 3'd0, 3'd1, 3'd0, 3'd0, 1'b1), enc(3'd2, 3'd0, 3'd2, 3'd0, 3'd0, 1'b1),
             enc(3'd0, 3'd0, 3'd3, 3'd1, 3'd2, 1'b0), enc(3'd0, 3'd1, 3'd4, 3'd2, 3'd2, 1'b0)};
    immw = '{16'hFFFF, 16'h0001, 16'h0000, 16'h0000};
    ev   = '{16'hFFFF, 16'h0001, 16'h0000, 16'h0003};
    ec   = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      bit  g;
      int  l;
      expT e;
      push(w[i][9:7], ev[i], ec[i], w[i][0] ? 3 : 2);
      runInstr(w[i], w[i][0], immw[i], 0, g, l);
      e = sb.pop_front();
      dbg_addr = e.rd;
      #1;
      total++;
      if (g !== 1'b1 || l != e.lat) $display("FAIL arith%0d_latency: got done=%0b lat=%0d, expected lat %0d", i, g, l, e.lat);
      else passed++;
      total++;
      if (dbg_data !== e.val) $display("FAIL arith%0d_r%0d: got %h, expected %h", i, e.rd, dbg_data, e.val);
      else passed++;
      total++;
      if (carry_flag !== e.c) $display("FAIL arith%0d_carry: got %0b, expected %0b", i, carry_flag, e.c);
      else passed++;
    end
  endtask

  task automatic test_shift();
    bit  g;
    int  l;
    expT e;
    push(3'd1, 16'h8001, 1'b0, 3);
    runInstr(enc(3'd2, 3'd0, 3'd1, 3'd0, 3'd0, 1'b1), 1'b1, 16'h8001, 0, g, l);
    e = sb.pop_front();
    dbg_addr = e.rd;
    #1;
    total++;
    if (g !== 1'b1 || dbg_data !== e.val) $display("FAIL shift_setup_r1: got done=%0b r1=%h, expected %h", g, dbg_data, e.val);
    else passed++;
    push(3'd1, 16'h0002, 1'b1, 2);
    total++;
    if (alu_enable_shift !== 1'b0) $display("FAIL shift_enable_idle: got %0b, expected 0", alu_enable_shift);
    else passed++;
    instr_valid = 1'b1;
    instr_data = enc(3'd1, 3'd1, 3'd1, 3'd1, 3'd0, 1'b0);
    @(negedge clk);
    instr_valid = 1'b0;
    total++;
    if ({alu_enable_alu, alu_enable_shift, alu_enable_load, alu_operation} !== 6'b010_001)
      $display("FAIL shift_exec_ctrl: got en/op=%b, expected 010001",
               {alu_enable_alu, alu_enable_shift, alu_enable_load, alu_operation});
    else passed++;
    total++;
    if (alu_operand1 !== 16'h8001) $display("FAIL shift_exec_operand1: got %h, expected 8001", alu_operand1);
    else passed++;
    @(negedge clk);
    total++;
    if ({done, alu_enable_alu, alu_enable_shift, alu_enable_load, alu_operation} !== 7'b1_000_000)
      $display("FAIL shift_wb_ctrl: got done/en/op=%b, expected 1000000",
               {done, alu_enable_alu, alu_enable_shift, alu_enable_load, alu_operation});
    else passed++;
    @(negedge clk);
    e = sb.pop_front();
    dbg_addr = e.rd;
    #1;
    total++;
    if (dbg_data !== e.val) $display("FAIL shift_r1: got %h, expected %h", dbg_data, e.val);
    else passed++;
    total++;
    if (carry_flag !== e.c) $display("FAIL shift_carry: got %0b, expected %0b", carry_flag, e.c);
    else passed++;
  endtask

  task automatic test_illegal();
    logic [15:0] bad [2];
    bad = '{16'h6000, enc(3'd1, 3'd7, 3'd1, 3'd1, 3'd1, 1'b0)};
    for (int i = 0; i < 2; i++) begin
      instr_valid = 1'b1;
      instr_data = bad[i];
      @(negedge clk);
      instr_valid = 1'b0;
      total++;
      if ({error, instr_ready, done} !== 3'b110)
        $display("FAIL illegal%0d_pulse: got error/ready/done=%b, expected 110", i, {error, instr_ready, done});
      else passed++;
      @(negedge clk);
      total++;
      if (error !== 1'b0) $display("FAIL illegal%0d_error_clear: got %0b, expected 0", i, error);
      else passed++;
    end
    for (int j = 0; j < 8; j++) begin
      dbg_addr = 3'(j);
      #1;
      total++;
      if (dbg_data !== mdlRead(3'(j))) $display("FAIL illegal_reg%0d: got %h, expected %h", j, dbg_data, mdlRead(3'(j)));
      else passed++;
      @(negedge clk);
    end
    total++;
    if (carry_flag !== mdlCarry) $display("FAIL illegal_carry: got %0b, expected %0b", carry_flag, mdlCarry);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] w [3];
    int          acc [3];
    int          k;
    int          doneCnt;
    w = '{enc(3'd0, 3'd0, 3'd5, 3'd1, 3'd2, 1'b0), enc(3'd0, 3'd2, 3'd6, 3'd2, 3'd4, 1'b0),
          enc(3'd0, 3'd4, 3'd7, 3'd1, 3'd2, 1'b0)};
    for (int i = 0; i < 3; i++) predict(w[i], 16'h0000, 2);
    acc = '{0, 0, 0};
    k = 0;
    doneCnt = 0;
    instr_valid = 1'b1;
    instr_data = w[0];
    for (int n = 0; n < 40 && (k < 3 || doneCnt < 3); n++) begin
      if (done) doneCnt++;
      if (instr_valid && instr_ready) begin
        acc[k] = cycle;
        k++;
      end
      @(negedge clk);
      if (k < 3) instr_data = w[k];
      else instr_valid = 1'b0;
    end
    instr_valid = 1'b0;
    total++;
    if (k != 3 || doneCnt != 3) $display("FAIL b2b_counts: got accepted=%0d done=%0d, expected 3 and 3", k, doneCnt);
    else passed++;
    total++;
    if (acc[1] - acc[0] != 3 || acc[2] - acc[1] != 3)
      $display("FAIL b2b_spacing: got %0d and %0d cycles, expected 3 and 3", acc[1] - acc[0], acc[2] - acc[1]);
    else passed++;
    while (sb.size() > 0) begin
      expT e;
      e = sb.pop_front();
      dbg_addr = e.rd;
      #1;
      total++;
      if (dbg_data !== e.val) $display("FAIL b2b_r%0d: got %h, expected %h", e.rd, dbg_data, e.val);
      else passed++;
      @(negedge clk);
    end
    total++;
    if (carry_flag !== mdlCarry) $display("FAIL b2b_carry: got %0b, expected %0b", carry_flag, mdlCarry);
    else passed++;
  endtask

  task automatic test_reset_mid();
    bit doneSeen;
    instr_valid = 1'b1;
    instr_data = enc(3'd0, 3'd0, 3'd5, 3'd1, 3'd2, 1'b0);
    @(negedge clk);
    instr_valid = 1'b0;
    total++;
    if (alu_enable_alu !== 1'b1) $display("FAIL rstmid_in_exec: got enable_alu=%0b, expected 1", alu_enable_alu);
    else passed++;
    reset = 1'b1;
    doneSeen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) doneSeen = 1'b1;
    end
    total++;
    if (instr_ready !== 1'b0 || alu_enable_alu !== 1'b0)
      $display("FAIL rstmid_outputs: got ready=%0b enable_alu=%0b, expected 0 and 0", instr_ready, alu_enable_alu);
    else passed++;
    reset = 1'b0;
    for (int j = 0; j < 8; j++) mdlReg[j] = 16'h0000;
    mdlCarry = 1'b0;
    dbg_addr = 3'd5;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (done) doneSeen = 1'b1;
    end
    total++;
    if (doneSeen !== 1'b0) $display("FAIL rstmid_done: got done pulse, expected none");
    else passed++;
    total++;
    if (dbg_data !== 16'h0000 || carry_flag !== 1'b0)
      $display("FAIL rstmid_r5: got r5=%h carry=%0b, expected 0000 and 0", dbg_data, carry_flag);
    else passed++;
  endtask

  task automatic test_r0();
    logic [15:0] w [4];
    logic [15:0] immw [4];
    w    = '{enc(3'd2, 3'd0, 3'd1, 3'd0, 3'd0, 1'b1), enc(3'd2, 3'd0, 3'd2, 3'd0, 3'd0, 1'b1),
             enc(3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 1'b0), enc(3'd0, 3'd0, 3'd6, 3'd0, 3'd2, 1'b0)};
    immw = '{16'hFFF5, 16'h0013, 16'h0000, 16'h0000};
    for (int i = 0; i < 4; i++) begin
      bit  g;
      int  l;
      expT e;
      predict(w[i], immw[i], w[i][0] ? 3 : 2);
      runInstr(w[i], w[i][0], immw[i], 0, g, l);
      e = sb.pop_front();
      dbg_addr = e.rd;
      #1;
      total++;
      if (g !== 1'b1 || l != e.lat) $display("FAIL r0_step%0d_latency: got done=%0b lat=%0d, expected lat %0d", i, g, l, e.lat);
      else passed++;
      total++;
      if (dbg_data !== e.val) $display("FAIL r0_step%0d_r%0d: got %h, expected %h", i, e.rd, dbg_data, e.val);
      else passed++;
      total++;
      if (carry_flag !== e.c) $display("FAIL r0_step%0d_carry: got %0b, expected %0b", i, carry_flag, e.c);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_ldli();
    test_arith();
    test_shift();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_r0();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
    $fatal(1);
  end

endmodule
